addsub_seq: RTL and testbench



---
 rtl/addsub_seq.sv | 144 ++++++++++++++
 tb/tb_addsub_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle two's-complement adder/subtractor.
//
// Operands are split into CHUNK-bit slices and one slice is added per clock.
// The slice carry is registered between cycles, so a wide add only ever has
// a CHUNK-bit carry chain. Subtraction is X + ~Y + 1: Y is inverted at
// accept time and the initial carry is set to Sub.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request (X, Y, Sub valid)
//   in_ready   high while idle; an operation is accepted on in_valid && in_ready
//   X, Y       WIDTH-bit operands
//   Sub        1: S = X - Y, 0: S = X + Y
//   out_valid  result and flags valid, held until out_ready
//   out_ready  consumer accepts the result
//   S          WIDTH-bit result, modulo 2^WIDTH
//   Cout       carry out of the MSB (for Sub, 1 = no borrow)
//   V          signed overflow
//   Z          S == 0
//   N          S[WIDTH-1]
//
// WIDTH must be a multiple of CHUNK. Latency from accept to out_valid is
// WIDTH/CHUNK cycles.

module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             V,
   output logic             Z,
   output logic             N
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDXW-1:0]  idx;
   logic             carry;
   logic [WIDTH-1:0] x_op;
   logic [WIDTH-1:0] y_eff;
   // Partial sum under construction; S is only updated once the last slice
   // is in, so a result that is still being computed is never visible.
   logic [WIDTH-1:0] acc;

   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] acc_next;

   // Add the current slice and merge it into the partial sum.
   always_comb begin
      slice_sum = {1'b0, x_op[idx*CHUNK +: CHUNK]}
                + {1'b0, y_eff[idx*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
      acc_next  = acc;
      acc_next[idx*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   // Control FSM with registered handshake outputs, result and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         x_op      <= '0;
         y_eff     <= '0;
         acc       <= '0;
         S         <= '0;
         Cout      <= 1'b0;
         V         <= 1'b0;
         Z         <= 1'b0;
         N         <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_op     <= X;
                  y_eff    <= Y ^ {WIDTH{Sub}};
                  carry    <= Sub;
                  idx      <= '0;
                  acc      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc   <= acc_next;
               carry <= slice_sum[CHUNK];
               if (idx == LAST_IDX) begin
                  // Flags come from the complete sum, not from any one slice.
                  S         <= acc_next;
                  Cout      <= slice_sum[CHUNK];
                  V         <= (x_op[WIDTH-1] == y_eff[WIDTH-1]) &&
                               (acc_next[WIDTH-1] != x_op[WIDTH-1]);
                  Z         <= (acc_next == '0);
                  N         <= acc_next[WIDTH-1];
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end else begin
                  state <= DONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq.
// Instance a: WIDTH=32/CHUNK=8, directed vectors, handshake, backpressure,
// back-to-back spacing, asynchronous reset mid-operation, random ops.
// Sweep instances: WIDTH=16/CHUNK=16 and WIDTH=64/CHUNK=8, 1000 random ops
// each with random backpressure. Expected results are queued at accept time
// and popped by per-instance monitors when a result is handed over.

module tb_addsub_seq;

   logic clk;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   logic b_rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [67:0] got, input logic [67:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Reference: sum/difference from plain arithmetic, Cout as "no wrap /
   // no borrow", V as "true signed result out of range".
   function automatic logic [67:0] ref_model(input int w, input logic [63:0] x,
                                             input logic [63:0] y, input logic sub);
      logic [63:0] mask, s;
      logic [64:0] sum;
      logic cout, v;
      logic signed [65:0] sx, sy, r, lim;
      mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      if (sub) begin
         s    = (x - y) & mask;
         cout = (x >= y);
      end else begin
         sum  = {1'b0, x} + {1'b0, y};
         s    = sum[63:0] & mask;
         cout = sum[w];
      end
      sx = $signed({2'b00, x});
      if (x[w-1]) sx = sx - (66'sd1 <<< w);
      sy = $signed({2'b00, y});
      if (y[w-1]) sy = sy - (66'sd1 <<< w);
      r   = sub ? (sx - sy) : (sx + sy);
      lim = 66'sd1 <<< (w - 1);
      v   = (r >= lim) || (r < -lim);
      return {cout, v, (s == 64'd0), s[w-1], s};
   endfunction

   // Operand picker biased towards boundary values.
   function automatic logic [63:0] pick(input int w);
      logic [63:0] mask;
      mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return mask;
         2:       return 64'd1 << (w - 1);
         3:       return mask >> 1;
         4:       return 64'd1;
         default: return {$urandom, $urandom} & mask;
      endcase
   endfunction

   // ---------------- instance a: 32/8 ----------------
   logic        a_rst_n, a_in_valid, a_in_ready, a_sub, a_out_valid, a_out_ready;
   logic        a_cout, a_v, a_z, a_n;
   logic [31:0] a_x, a_y, a_s;
   logic [67:0] qa[$];

   addsub_seq #(.WIDTH(32), .CHUNK(8)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .X(a_x), .Y(a_y), .Sub(a_sub), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .S(a_s), .Cout(a_cout), .V(a_v), .Z(a_z), .N(a_n)
   );

   function automatic logic [67:0] a_got();
      return {a_cout, a_v, a_z, a_n, 32'd0, a_s};
   endfunction

   initial begin : mon_a
      forever begin
         @(negedge clk);
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_spurious: got out_valid=1 required no pending result");
            end else begin
               check("a_result", a_got(), qa.pop_front());
            end
         end
      end
   end

   // Called at posedge+1; returns at accept edge+1.
   task automatic a_issue(input logic [31:0] x, input logic [31:0] y, input logic sub,
                          input logic [67:0] exp);
      int wt;
      wt = 0;
      while (!a_in_ready && wt < 40) begin
         @(posedge clk);
         #1;
         wt++;
      end
      check("a_in_ready_before_issue", {67'd0, a_in_ready}, 68'd1);
      a_x = x;
      a_y = y;
      a_sub = sub;
      a_in_valid = 1'b1;
      @(posedge clk);
      qa.push_back(exp);
      #1;
      // Scramble operands while the operation is in flight.
      a_in_valid = 1'b0;
      a_x = $urandom;
      a_y = $urandom;
      a_sub = 1'($urandom);
   endtask

   task automatic a_wait_valid(output int lat);
      lat = 0;
      while (!a_out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic a_rand_op();
      logic [63:0] rx, ry;
      logic rs;
      rx = pick(32);
      ry = pick(32);
      rs = 1'($urandom);
      a_issue(rx[31:0], ry[31:0], rs, ref_model(32, rx, ry, rs));
   endtask

   // ---------------- sweep instances ----------------
   for (genvar g = 0; g < 2; g++) begin : sweep
      localparam int W = (g == 0) ? 16 : 64;
      localparam int C = (g == 0) ? 16 : 8;
      logic         in_valid, in_ready, sub, out_valid, out_ready;
      logic         cout, v, z, n;
      logic [W-1:0] x, y, s;
      logic [67:0]  q[$];
      logic         done_flag;

      addsub_seq #(.WIDTH(W), .CHUNK(C)) dut (
         .clk(clk), .rst_n(b_rst_n), .in_valid(in_valid), .in_ready(in_ready),
         .X(x), .Y(y), .Sub(sub), .out_valid(out_valid), .out_ready(out_ready),
         .S(s), .Cout(cout), .V(v), .Z(z), .N(n)
      );

      initial begin : drv
         int wt;
         logic [63:0] rx, ry;
         logic rs;
         done_flag = 1'b0;
         in_valid = 1'b0;
         x = '0;
         y = '0;
         sub = 1'b0;
         wait (b_rst_n === 1'b1);
         @(posedge clk);
         #1;
         for (int i = 0; i < 1000; i++) begin
            wt = 0;
            while (!in_ready && wt < 200) begin
               @(posedge clk);
               #1;
               wt++;
            end
            if (wt >= 200) begin
               checks++;
               errors++;
               $display("FAIL sweep_w%0d_accept_timeout: got in_ready=0 required 1", W);
               break;
            end
            rx = pick(W);
            ry = pick(W);
            rs = 1'($urandom);
            x = W'(rx);
            y = W'(ry);
            sub = rs;
            in_valid = 1'b1;
            @(posedge clk);
            q.push_back(ref_model(W, rx, ry, rs));
            #1;
            in_valid = 1'b0;
            x = W'({$urandom, $urandom});
            y = W'({$urandom, $urandom});
            sub = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
         wt = 0;
         while (q.size() != 0 && wt < 500) begin
            @(posedge clk);
            wt++;
         end
         if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sweep_w%0d_drain: got %0d pending required 0", W, q.size());
         end
         done_flag = 1'b1;
      end

      initial begin : rdy
         out_ready = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
         end
      end

      initial begin : mon
         forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sweep_w%0d_spurious: got out_valid=1 required no pending result", W);
               end else begin
                  check($sformatf("sweep_w%0d_result", W), {cout, v, z, n, 64'(s)}, q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [31:0] dx[5], dy[5];
      logic        ds[5];
      logic [67:0] de[5], exp;
      logic [63:0] rx, ry;
      logic        rs;
      int          lat, wt;
      int          acc_cyc[5];

      dx[0] = 32'd136;        dy[0] = 32'd17;         ds[0] = 1'b1; de[0] = 68'h8_0000000000000077;
      dx[1] = 32'hFFFFFFFF;   dy[1] = 32'hFFFFFFFE;   ds[1] = 1'b1; de[1] = 68'h8_0000000000000001;
      dx[2] = 32'h00000000;   dy[2] = 32'h00000001;   ds[2] = 1'b1; de[2] = 68'h1_00000000FFFFFFFF;
      dx[3] = 32'h7FFFFFFF;   dy[3] = 32'h00000001;   ds[3] = 1'b0; de[3] = 68'h5_0000000080000000;
      dx[4] = 32'hFFFFFFFF;   dy[4] = 32'h00000001;   ds[4] = 1'b0; de[4] = 68'hA_0000000000000000;

      a_rst_n = 1'b0;
      b_rst_n = 1'b0;
      a_in_valid = 1'b0;
      a_x = 32'd0;
      a_y = 32'd0;
      a_sub = 1'b0;
      a_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", a_got(), 68'd0);
      check("reset_handshake", {66'd0, a_out_valid, a_in_ready}, 68'd1);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors with latency check.
      for (int i = 0; i < 5; i++) begin
         a_issue(dx[i], dy[i], ds[i], de[i]);
         a_wait_valid(lat);
         check("a_latency", 68'(lat), 68'd4);
      end

      // Backpressure: result must stay put, in_valid must be ignored.
      @(posedge clk);
      #1;
      a_out_ready = 1'b0;
      rx = pick(32);
      ry = pick(32);
      rs = 1'($urandom);
      exp = ref_model(32, rx, ry, rs);
      a_issue(rx[31:0], ry[31:0], rs, exp);
      a_wait_valid(lat);
      check("bp_latency", 68'(lat), 68'd4);
      a_in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_hold_result", a_got(), exp);
         check("bp_hold_handshake", {66'd0, a_out_valid, a_in_ready}, 68'd2);
      end
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_handshake", {66'd0, a_out_valid, a_in_ready}, 68'd1);

      // Back-to-back with out_ready tied high: accepts every 6 cycles.
      for (int i = 0; i < 5; i++) begin
         a_rand_op();
         acc_cyc[i] = cyc;
         if (i > 0) check("b2b_spacing", 68'(acc_cyc[i] - acc_cyc[i-1]), 68'd6);
      end

      // Asynchronous reset in the middle of CALC.
      a_rand_op();
      @(posedge clk);
      @(posedge clk);
      #3;
      a_rst_n = 1'b0;
      #1;
      check("abort_result", a_got(), 68'd0);
      check("abort_handshake", {66'd0, a_out_valid, a_in_ready}, 68'd1);
      qa.delete();
      @(negedge clk);
      a_rst_n = 1'b1;
      @(posedge clk);
      #1;
      a_rand_op();
      a_wait_valid(lat);
      check("post_reset_latency", 68'(lat), 68'd4);

      // Random ops on the 32-bit instance.
      for (int i = 0; i < 60; i++) a_rand_op();
      wt = 0;
      while (qa.size() != 0 && wt < 100) begin
         @(posedge clk);
         wt++;
      end
      check("a_drain", 68'(qa.size()), 68'd0);

      wt = 0;
      while (!(sweep[0].done_flag && sweep[1].done_flag) && wt < 40000) begin
         @(posedge clk);
         wt++;
      end
      check("sweep_complete", {66'd0, sweep[1].done_flag, sweep[0].done_flag}, 68'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
